// File: rtl/onehot_decode_seq_pkg.sv
// Shared types for the one-hot decode sequencer.
package onehot_pkg;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SWEEP  = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

endpackage

// File: rtl/onehot_decode_seq_if.sv
// Request/beat handshake bundle for onehot_decode_seq.
interface onehot_decode_seq_if
  import onehot_pkg::*;
#(
  parameter int IDX_W     = 7,
  parameter int NUM_LINES = 2 ** IDX_W
) ();

  logic                 in_valid;
  logic                 in_ready;
  mode_t                in_mode;
  logic [IDX_W-1:0]     in_idx;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_LINES-1:0] out_onehot;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 out_err;
  logic                 busy;

  // Requester / beat consumer side
  modport master (
    output in_valid, in_mode, in_idx, abort, out_ready,
    input  in_ready, out_valid, out_onehot, out_idx, out_last, out_err, busy
  );

  // Decoder side
  modport slave (
    input  in_valid, in_mode, in_idx, abort, out_ready,
    output in_ready, out_valid, out_onehot, out_idx, out_last, out_err, busy
  );

endinterface

// File: rtl/onehot_decode_seq_decode.sv
// Combinational index to one-hot decoder with out-of-range flag.
module onehot_decode #(
  parameter int IDX_W     = 7,
  parameter int NUM_LINES = 2 ** IDX_W
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_LINES-1:0] onehot,
  output logic                 range_err
);

  // One extra bit so NUM_LINES == 2**IDX_W is representable
  localparam logic [IDX_W:0]     LIMIT = (IDX_W + 1)'(NUM_LINES);
  localparam logic [NUM_LINES-1:0] ONE = NUM_LINES'(1);

  // Shift a single set bit into place; out-of-range indices give all-zero
  always_comb begin
    range_err = ({1'b0, idx} >= LIMIT);
    onehot    = range_err ? '0 : (ONE << idx);
  end

endmodule

// File: rtl/onehot_decode_seq.sv
// Registered one-hot decoder with SINGLE and SWEEP request modes.
module onehot_decode_seq
  import onehot_pkg::*;
#(
  parameter int IDX_W     = 7,
  parameter int NUM_LINES = 2 ** IDX_W
) (
  input logic                clk,
  input logic                rst,
  onehot_decode_seq_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  state_t               state;
  logic [IDX_W-1:0]     cnt;
  logic                 adv;
  logic                 accept;
  logic [IDX_W-1:0]     dec_idx;
  logic [NUM_LINES-1:0] dec_oh;
  logic                 dec_err;

  logic                 ov;
  logic [NUM_LINES-1:0] ooh;
  logic [IDX_W-1:0]     oidx;
  logic                 olast;
  logic                 oerr;

  // Handshake qualifiers and decoder operand selection
  always_comb begin
    adv     = !ov | bus.out_ready;
    accept  = bus.in_valid & (state == ST_IDLE) & adv;
    dec_idx = (state == ST_IDLE) ? bus.in_idx : cnt;
  end

  onehot_decode #(
    .IDX_W     (IDX_W),
    .NUM_LINES (NUM_LINES)
  ) u_decode (
    .idx       (dec_idx),
    .onehot    (dec_oh),
    .range_err (dec_err)
  );

  // FSM, sweep counter and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ov    <= 1'b0;
      ooh   <= '0;
      oidx  <= '0;
      olast <= 1'b0;
      oerr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ov   <= 1'b1;
            oidx <= bus.in_idx;
            ooh  <= dec_oh;
            oerr <= dec_err;
            // A sweep starting on the final line is a one-beat request and
            // never enters SWEEP; cnt holds the next line to issue.
            if (bus.in_mode == MODE_SWEEP && !dec_err && bus.in_idx != LAST_IDX) begin
              state <= ST_SWEEP;
              olast <= 1'b0;
              cnt   <= bus.in_idx + 1'b1;
            end else begin
              olast <= 1'b1;
            end
          end else if (adv) begin
            ov    <= 1'b0;
            ooh   <= '0;
            oidx  <= '0;
            olast <= 1'b0;
            oerr  <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (bus.abort) begin
            // Pending beat is kept as-is; only a consumed one is cleared
            state <= ST_IDLE;
            if (adv) begin
              ov    <= 1'b0;
              ooh   <= '0;
              oidx  <= '0;
              olast <= 1'b0;
              oerr  <= 1'b0;
            end
          end else if (adv) begin
            ov    <= 1'b1;
            oidx  <= cnt;
            ooh   <= dec_oh;
            oerr  <= dec_err;
            olast <= (cnt == LAST_IDX);
            if (cnt == LAST_IDX) begin
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == ST_IDLE) & adv;
  assign bus.busy       = (state == ST_SWEEP);
  assign bus.out_valid  = ov;
  assign bus.out_onehot = ooh;
  assign bus.out_idx    = oidx;
  assign bus.out_last   = olast;
  assign bus.out_err    = oerr;

endmodule
